axi_cdc_quiesce: RTL and testbench

//  Single-clock AXI stage placed directly upstream of axi_cdc src side, in the src clock domain.

---
 rtl/axi_cdc_quiesce.sv | 193 +++++++++++++++++++
 tb/tb_axi_cdc_quiesce.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cdc_quiesce.sv
// Quiesce stage for the source side of an AXI clock-domain crossing. It bounds the number of
// outstanding writes and reads, and on request drains the port and blocks new AW/AR.

package axi_cdc_quiesce_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } rsp_t;

endpackage

module axi_cdc_quiesce #(
    parameter int unsigned MaxTxns  = 8,
    parameter type         axi_req_t = axi_cdc_quiesce_pkg::req_t,
    parameter type         axi_rsp_t = axi_cdc_quiesce_pkg::rsp_t,
    localparam int unsigned CntWidth = $clog2(MaxTxns + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                isolate_i,
    output logic                isolated_o,
    output logic [CntWidth-1:0] wr_outstanding_o,
    output logic [CntWidth-1:0] rd_outstanding_o,
    input  axi_req_t            slv_req_i,
    output axi_rsp_t            slv_resp_o,
    output axi_req_t            mst_req_o,
    input  axi_rsp_t            mst_resp_i
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } state_t;

    // Counter slots: outstanding writes, outstanding reads, W bursts owed to accepted AWs.
    localparam int NumCnt = 3;
    localparam int WrIdx  = 0;
    localparam int RdIdx  = 1;
    localparam int WoIdx  = 2;
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxns);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    state_t              state_reg;
    state_t              state_next;
    logic                isolated_reg;
    logic [CntWidth-1:0] cnt_reg  [NumCnt];
    logic [CntWidth-1:0] cnt_next [NumCnt];
    logic [NumCnt-1:0]   cnt_inc;
    logic [NumCnt-1:0]   cnt_dec;

    logic aw_en;
    logic ar_en;
    logic w_en;
    logic aw_hs;
    logic ar_hs;
    logic w_last_hs;
    logic b_hs;
    logic r_last_hs;
    logic all_idle;

    assign aw_en = (state_reg == RUN) && (cnt_reg[WrIdx] < CntMax);
    assign ar_en = (state_reg == RUN) && (cnt_reg[RdIdx] < CntMax);

    assign aw_hs = slv_req_i.aw_valid && mst_resp_i.aw_ready && aw_en;
    assign ar_hs = slv_req_i.ar_valid && mst_resp_i.ar_ready && ar_en;

    // W may ride along with its own AW in the same cycle, but never ahead of it.
    assign w_en      = (cnt_reg[WoIdx] != '0) || aw_hs;
    assign w_last_hs = slv_req_i.w_valid && mst_resp_i.w_ready && w_en && slv_req_i.w.last;
    assign b_hs      = mst_resp_i.b_valid && slv_req_i.b_ready;
    assign r_last_hs = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;

    assign cnt_inc = {aw_hs, ar_hs, aw_hs};
    assign cnt_dec = {w_last_hs, r_last_hs, b_hs};

    generate
        for (genvar gi = 0; gi < NumCnt; gi++) begin : g_cnt
            assign cnt_next[gi] =
                (cnt_inc[gi] && !cnt_dec[gi] && (cnt_reg[gi] != CntMax)) ? cnt_reg[gi] + CntOne :
                (cnt_dec[gi] && !cnt_inc[gi] && (cnt_reg[gi] != '0))     ? cnt_reg[gi] - CntOne :
                                                                            cnt_reg[gi];

            // A lone decrement with nothing outstanding means a peer broke the protocol.
            assert property (@(posedge clk_i) disable iff (rst_i)
                !(cnt_dec[gi] && !cnt_inc[gi] && (cnt_reg[gi] == '0)));
        end
    endgenerate

    // Idle test uses registered counts, so a completion this cycle is seen next cycle.
    assign all_idle = (cnt_reg[WrIdx] == '0) && (cnt_reg[RdIdx] == '0) && (cnt_reg[WoIdx] == '0);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN: begin
                if (isolate_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!isolate_i) begin
                    state_next = RUN;
                end else if (all_idle) begin
                    state_next = ISOLATED;
                end
            end
            ISOLATED: begin
                if (!isolate_i) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= RUN;
            isolated_reg <= 1'b0;
            for (int i = 0; i < NumCnt; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            isolated_reg <= (state_next == ISOLATED);
            for (int i = 0; i < NumCnt; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    // Payloads and B/R pass untouched; only AW/W/AR valid and ready are gated.
    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = slv_req_i.aw_valid & aw_en;
        mst_req_o.w_valid  = slv_req_i.w_valid & w_en;
        mst_req_o.ar_valid = slv_req_i.ar_valid & ar_en;

        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_en;
        slv_resp_o.w_ready  = mst_resp_i.w_ready & w_en;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_en;
    end

    assign isolated_o       = isolated_reg;
    assign wr_outstanding_o = cnt_reg[WrIdx];
    assign rd_outstanding_o = cnt_reg[RdIdx];

endmodule

// File: tb/tb_axi_cdc_quiesce.sv
// Directed bench for axi_cdc_quiesce: a vector table for the basic write/read flow plus
// hand-written sequences for limit, isolation, drain, W-ordering and reset corners.

module tb_axi_cdc_quiesce;
    import axi_cdc_quiesce_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iso = 1'b0;
    logic       isolated;
    logic [3:0] wr_out;
    logic [3:0] rd_out;
    req_t       slv_req;
    req_t       mst_req;
    rsp_t       slv_resp;
    rsp_t       mst_resp;

    int checks = 0;
    int errors = 0;

    // in_bits : {iso, aw_valid, aw_ready, w_valid, w_last, w_ready, b_valid, b_ready,
    //            ar_valid, ar_ready, r_valid, r_last, r_ready}
    // exp_bits: {slv aw_ready, mst aw_valid, mst w_valid, slv w_ready, mst ar_valid, slv ar_ready}
    typedef struct {
        logic [12:0] in_bits;
        logic [5:0]  exp_bits;
        int          wc;
        int          rc;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    axi_cdc_quiesce #(.MaxTxns(8)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .isolate_i        (iso),
        .isolated_o       (isolated),
        .wr_outstanding_o (wr_out),
        .rd_outstanding_o (rd_out),
        .slv_req_i        (slv_req),
        .slv_resp_o       (slv_resp),
        .mst_req_o        (mst_req),
        .mst_resp_i       (mst_resp)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payloads();
        slv_req.aw  = '{id: 4'($urandom), addr: $urandom, len: 8'($urandom)};
        slv_req.ar  = '{id: 4'($urandom), addr: $urandom, len: 8'($urandom)};
        slv_req.w   = '{data: $urandom, strb: 4'($urandom), last: 1'b0};
        mst_resp.b  = '{id: 4'($urandom), resp: 2'($urandom)};
        mst_resp.r  = '{id: 4'($urandom), data: $urandom, resp: 2'($urandom), last: 1'b0};
    endtask

    task automatic idle_inputs();
        slv_req  = '0;
        mst_resp = '0;
        rand_payloads();
    endtask

    task automatic do_reset();
        idle_inputs();
        iso = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset isolated", isolated, 0);
        check("reset wr_cnt", wr_out, 0);
        check("reset rd_cnt", rd_out, 0);
    endtask

    task automatic check_passthru(input int idx);
        check($sformatf("v%0d aw payload", idx), 64'(mst_req.aw), 64'(slv_req.aw));
        check($sformatf("v%0d w payload", idx), 64'(mst_req.w), 64'(slv_req.w));
        check($sformatf("v%0d ar payload", idx), 64'(mst_req.ar), 64'(slv_req.ar));
        check($sformatf("v%0d b payload", idx), 64'(slv_resp.b), 64'(mst_resp.b));
        check($sformatf("v%0d r payload", idx), 64'(slv_resp.r), 64'(mst_resp.r));
        check($sformatf("v%0d b_valid", idx), slv_resp.b_valid, mst_resp.b_valid);
        check($sformatf("v%0d b_ready", idx), mst_req.b_ready, slv_req.b_ready);
        check($sformatf("v%0d r_valid", idx), slv_resp.r_valid, mst_resp.r_valid);
        check($sformatf("v%0d r_ready", idx), mst_req.r_ready, slv_req.r_ready);
    endtask

    task automatic apply(input vec_t v, input int idx);
        rand_payloads();
        {iso, slv_req.aw_valid, mst_resp.aw_ready, slv_req.w_valid, slv_req.w.last,
         mst_resp.w_ready, mst_resp.b_valid, slv_req.b_ready, slv_req.ar_valid,
         mst_resp.ar_ready, mst_resp.r_valid, mst_resp.r.last, slv_req.r_ready} = v.in_bits;
        #1;
        check($sformatf("v%0d slv aw_ready", idx), slv_resp.aw_ready, v.exp_bits[5]);
        check($sformatf("v%0d mst aw_valid", idx), mst_req.aw_valid, v.exp_bits[4]);
        check($sformatf("v%0d mst w_valid", idx), mst_req.w_valid, v.exp_bits[3]);
        check($sformatf("v%0d slv w_ready", idx), slv_resp.w_ready, v.exp_bits[2]);
        check($sformatf("v%0d mst ar_valid", idx), mst_req.ar_valid, v.exp_bits[1]);
        check($sformatf("v%0d slv ar_ready", idx), slv_resp.ar_ready, v.exp_bits[0]);
        check($sformatf("v%0d wr_cnt", idx), wr_out, v.wc);
        check($sformatf("v%0d rd_cnt", idx), rd_out, v.rc);
        check($sformatf("v%0d isolated", idx), isolated, 0);
        check_passthru(idx);
        $display("vector %0d: in=%b wr=%0d rd=%0d", idx, v.in_bits, wr_out, rd_out);
        tick();
    endtask

    task automatic check_blocked(input string tag);
        check({tag, " slv aw_ready"}, slv_resp.aw_ready, 0);
        check({tag, " mst aw_valid"}, mst_req.aw_valid, 0);
        check({tag, " slv ar_ready"}, slv_resp.ar_ready, 0);
        check({tag, " mst ar_valid"}, mst_req.ar_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Test 1: three writes, two 4-beat reads; counts peak at 3/2 and drain to 0/0.
        vecs[0]  = '{13'b0_11_111_00_01_000, 6'b11_11_01, 0, 0};
        vecs[1]  = '{13'b0_11_111_00_01_000, 6'b11_11_01, 1, 0};
        vecs[2]  = '{13'b0_11_001_00_01_000, 6'b11_01_01, 2, 0};
        vecs[3]  = '{13'b0_01_111_00_11_000, 6'b10_11_11, 3, 0};
        vecs[4]  = '{13'b0_01_001_11_11_000, 6'b10_00_11, 3, 1};
        vecs[5]  = '{13'b0_01_001_11_01_101, 6'b10_00_01, 2, 2};
        vecs[6]  = '{13'b0_01_001_11_01_101, 6'b10_00_01, 1, 2};
        vecs[7]  = '{13'b0_01_001_00_01_101, 6'b10_00_01, 0, 2};
        vecs[8]  = '{13'b0_01_001_00_01_111, 6'b10_00_01, 0, 2};
        vecs[9]  = '{13'b0_01_001_00_01_101, 6'b10_00_01, 0, 1};
        vecs[10] = '{13'b0_01_001_00_01_101, 6'b10_00_01, 0, 1};
        vecs[11] = '{13'b0_01_001_00_01_101, 6'b10_00_01, 0, 1};
        vecs[12] = '{13'b0_01_001_00_01_111, 6'b10_00_01, 0, 1};
        vecs[13] = '{13'b0_01_111_00_01_000, 6'b10_00_01, 0, 0};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i], i);
        end
        check("t1 final wr_cnt", wr_out, 0);
        check("t1 final rd_cnt", rd_out, 0);

        // Test 2: limit of 8 outstanding writes with B held off.
        do_reset();
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        slv_req.b_ready   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            slv_req.aw_valid = 1'b1;
            slv_req.w_valid  = 1'b1;
            slv_req.w.last   = 1'b1;
            #1;
            check("t2 aw_ready accept", slv_resp.aw_ready, 1);
            check("t2 wr_cnt filling", wr_out, i);
            tick();
        end
        slv_req.w_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2 aw_ready full", slv_resp.aw_ready, 0);
            check("t2 mst aw_valid full", mst_req.aw_valid, 0);
            check("t2 wr_cnt full", wr_out, 8);
            tick();
        end
        mst_resp.b_valid = 1'b1;
        #1;
        check("t2 aw_ready during B", slv_resp.aw_ready, 0);
        tick();
        mst_resp.b_valid = 1'b0;
        slv_req.w_valid  = 1'b1;
        #1;
        check("t2 wr_cnt after B", wr_out, 7);
        check("t2 aw_ready after B", slv_resp.aw_ready, 1);
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid  = 1'b0;
        #1;
        check("t2 wr_cnt refilled", wr_out, 8);
        mst_resp.b_valid = 1'b1;
        repeat (8) tick();
        mst_resp.b_valid = 1'b0;
        #1;
        check("t2 wr_cnt drained", wr_out, 0);
        $display("test 2 done: write limit");

        // Test 3: idle isolation latency, AR stall, release.
        do_reset();
        mst_resp.ar_ready = 1'b1;
        slv_req.r_ready   = 1'b1;
        iso = 1'b1;
        tick();
        check("t3 isolated after 1", isolated, 0);
        tick();
        check("t3 isolated after 2", isolated, 1);
        slv_req.ar_valid = 1'b1;
        repeat (2) begin
            #1;
            check("t3 slv ar_ready isolated", slv_resp.ar_ready, 0);
            check("t3 mst ar_valid isolated", mst_req.ar_valid, 0);
            tick();
        end
        check("t3 rd_cnt isolated", rd_out, 0);
        iso = 1'b0;
        #1;
        check("t3 ar_ready release cycle", slv_resp.ar_ready, 0);
        tick();
        check("t3 isolated released", isolated, 0);
        check("t3 ar_ready run", slv_resp.ar_ready, 1);
        check("t3 mst ar_valid run", mst_req.ar_valid, 1);
        tick();
        slv_req.ar_valid = 1'b0;
        check("t3 rd_cnt after AR", rd_out, 1);
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b1;
        tick();
        mst_resp.r_valid = 1'b0;
        check("t3 rd_cnt after R", rd_out, 0);
        $display("test 3 done: idle isolation");

        // Test 4: drain with a write burst in flight.
        do_reset();
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        slv_req.b_ready   = 1'b1;
        slv_req.aw_valid  = 1'b1;
        slv_req.w_valid   = 1'b1;
        #1;
        check("t4 aw accepted", slv_resp.aw_ready, 1);
        tick();
        slv_req.aw_valid = 1'b0;
        iso = 1'b1;
        #1;
        check("t4 beat2 w_ready", slv_resp.w_ready, 1);
        tick();
        slv_req.aw_valid = 1'b1;
        slv_req.ar_valid = 1'b1;
        #1;
        check_blocked("t4 beat3");
        check("t4 beat3 w_ready", slv_resp.w_ready, 1);
        check("t4 beat3 isolated", isolated, 0);
        tick();
        slv_req.w.last = 1'b1;
        #1;
        check_blocked("t4 beat4");
        check("t4 beat4 w_ready", slv_resp.w_ready, 1);
        tick();
        slv_req.w_valid  = 1'b0;
        mst_resp.b_valid = 1'b1;
        #1;
        check_blocked("t4 B cycle");
        check("t4 B cycle wr_cnt", wr_out, 1);
        check("t4 B cycle isolated", isolated, 0);
        tick();
        mst_resp.b_valid = 1'b0;
        check("t4 after B isolated", isolated, 0);
        check("t4 after B wr_cnt", wr_out, 0);
        check_blocked("t4 after B");
        tick();
        check("t4 isolated", isolated, 1);
        check_blocked("t4 isolated");
        iso = 1'b0;
        slv_req.aw_valid = 1'b0;
        slv_req.ar_valid = 1'b0;
        tick();
        check("t4 released", isolated, 0);
        $display("test 4 done: drain with burst");

        // Test 5: W offered before its AW.
        do_reset();
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        slv_req.b_ready   = 1'b1;
        slv_req.w_valid   = 1'b1;
        slv_req.w.last    = 1'b1;
        repeat (2) begin
            #1;
            check("t5 w_ready before AW", slv_resp.w_ready, 0);
            check("t5 mst w_valid before AW", mst_req.w_valid, 0);
            tick();
        end
        slv_req.aw_valid = 1'b1;
        #1;
        check("t5 aw_ready", slv_resp.aw_ready, 1);
        check("t5 w_ready with AW", slv_resp.w_ready, 1);
        check("t5 mst w_valid with AW", mst_req.w_valid, 1);
        tick();
        slv_req.aw_valid = 1'b0;
        #1;
        check("t5 w_ready after burst", slv_resp.w_ready, 0);
        check("t5 wr_cnt", wr_out, 1);
        slv_req.w_valid  = 1'b0;
        mst_resp.b_valid = 1'b1;
        tick();
        mst_resp.b_valid = 1'b0;
        check("t5 wr_cnt after B", wr_out, 0);
        $display("test 5 done: W ordering");

        // Test 6: aborted drain, then reset with reads outstanding.
        do_reset();
        mst_resp.ar_ready = 1'b1;
        slv_req.r_ready   = 1'b1;
        slv_req.ar_valid  = 1'b1;
        tick();
        tick();
        slv_req.ar_valid = 1'b0;
        check("t6 rd_cnt 2", rd_out, 2);
        iso = 1'b1;
        tick();
        iso = 1'b0;
        slv_req.ar_valid = 1'b1;
        #1;
        check("t6 drain isolated", isolated, 0);
        check("t6 drain ar_ready", slv_resp.ar_ready, 0);
        check("t6 drain mst ar_valid", mst_req.ar_valid, 0);
        slv_req.ar_valid = 1'b0;
        tick();
        check("t6 run ar_ready", slv_resp.ar_ready, 1);
        check("t6 run isolated", isolated, 0);
        check("t6 run rd_cnt", rd_out, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6 reset rd_cnt", rd_out, 0);
        check("t6 reset wr_cnt", wr_out, 0);
        check("t6 reset isolated", isolated, 0);
        slv_req.w_valid  = 1'b1;
        slv_req.w.last   = 1'b1;
        mst_resp.w_ready = 1'b1;
        #1;
        check("t6 reset w_ready", slv_resp.w_ready, 0);
        check("t6 reset ar_ready", slv_resp.ar_ready, 1);
        $display("test 6 done: abort and reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
